// File: rtl/dp_pkg.sv
// Shared definitions for the downsampling datapath: ALU opcodes, read FSM
// state encoding and the register-select width helper.
package dp_pkg;

   localparam logic [2:0] OP_PASSA = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_SUB   = 3'd2;
   localparam logic [2:0] OP_INCB  = 3'd3;
   localparam logic [2:0] OP_SHR   = 3'd4;
   localparam logic [2:0] OP_SHL   = 3'd5;
   localparam logic [2:0] OP_AND   = 3'd6;
   localparam logic [2:0] OP_OR    = 3'd7;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } rd_state_e;

   // Select width wide enough to address NREG registers plus the AC slot.
   function automatic int unsigned sel_width(input int unsigned nreg);
      return $clog2(nreg + 1);
   endfunction

endpackage

// File: rtl/downsample_datapath_alu.sv
// Combinational ALU for the downsampling datapath; carry is only meaningful
// for add, subtract (borrow) and increment, and is zero for every other op.
module dp_alu
   import dp_pkg::*;
#(
   parameter int unsigned REG_W = 19
) (
   input  logic [2:0]       op_i,
   input  logic [REG_W-1:0] a_i,
   input  logic [REG_W-1:0] b_i,
   output logic [REG_W-1:0] result_c_o,
   output logic             carry_c_o
);

   localparam int unsigned SUM_W = REG_W + 1;

   logic [SUM_W-1:0] sum;

   always_comb begin
      sum        = '0;
      result_c_o = a_i;
      carry_c_o  = 1'b0;
      case (op_i)
         OP_PASSA: result_c_o = a_i;
         OP_ADD: begin
            sum        = {1'b0, a_i} + {1'b0, b_i};
            result_c_o = sum[REG_W-1:0];
            carry_c_o  = sum[REG_W];
         end
         OP_SUB: begin
            // Top bit of the widened difference is the borrow.
            sum        = {1'b0, b_i} - {1'b0, a_i};
            result_c_o = sum[REG_W-1:0];
            carry_c_o  = sum[REG_W];
         end
         OP_INCB: begin
            sum        = {1'b0, b_i} + SUM_W'(1);
            result_c_o = sum[REG_W-1:0];
            carry_c_o  = sum[REG_W];
         end
         OP_SHR:  result_c_o = b_i >> 1;
         OP_SHL:  result_c_o = b_i << 1;
         OP_AND:  result_c_o = a_i & b_i;
         OP_OR:   result_c_o = a_i | b_i;
         default: result_c_o = a_i;
      endcase
   end

endmodule

// File: rtl/downsample_datapath.sv
// Downsampling processor datapath: register file, accumulator, ALU buses,
// handshaked memory read into AC and registered zero/one/carry flags.
module downsample_datapath
   import dp_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned REG_W   = 19,
   parameter int unsigned NREG    = 8,
   parameter int unsigned MI_IDX  = 0,
   parameter int unsigned MO_IDX  = 1,
   parameter int unsigned MOD_IDX = 2,
   parameter int unsigned STRIDE  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0]                  ALU_OP,
   input  logic [sel_width(NREG)-1:0]  A_sel,
   input  logic [sel_width(NREG)-1:0]  B_sel,
   input  logic [NREG-1:0]             LOAD_VECT,
   input  logic [NREG-1:0]             CLEAR_VECT,
   input  logic [NREG-1:0]             INC_VECT,
   input  logic                        LD_ALU_AC,
   input  logic                        CLR_AC,
   input  logic                        MI_req,
   output logic                        MI_rd,
   input  logic                        MI_valid,
   input  logic [DATA_W-1:0]           MI_data,
   output logic                        busy,
   output logic [REG_W-1:0]            MI_add,
   output logic [REG_W-1:0]            MO_add,
   output logic [DATA_W-1:0]           MO_data,
   output logic                        z,
   output logic                        z1,
   output logic                        c
);

   localparam int unsigned SW = sel_width(NREG);
   localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [REG_W-1:0] reg_q [NREG];
   logic [REG_W-1:0] reg_d [NREG];
   logic [REG_W-1:0] ac_q;
   logic [REG_W-1:0] ac_d;
   logic             c_q;
   logic             c_d;
   logic             z_q;
   logic             z1_q;

   rd_state_e        state_q;
   logic             mi_rd_q;
   logic             busy_q;
   logic [REG_W-1:0] mi_add_q;

   logic [REG_W-1:0] a_bus;
   logic [REG_W-1:0] b_bus;
   logic [REG_W-1:0] alu_res;
   logic             alu_carry;

   // Bus muxes; out-of-range selects fall through to zero.
   always_comb begin
      a_bus = '0;
      b_bus = '0;
      for (int i = 0; i < int'(NREG); i++) begin
         if (A_sel == SW'(i)) a_bus = reg_q[i];
         if (B_sel == SW'(i)) b_bus = reg_q[i];
      end
      if (B_sel == SW'(NREG)) b_bus = ac_q;
   end

   dp_alu #(
      .REG_W (REG_W)
   ) u_alu (
      .op_i       (ALU_OP),
      .a_i        (a_bus),
      .b_i        (b_bus),
      .result_c_o (alu_res),
      .carry_c_o  (alu_carry)
   );

   // Register file next state: clear over load over increment over hold.
   always_comb begin
      for (int i = 0; i < int'(NREG); i++) begin
         reg_d[i] = reg_q[i];
         if (CLEAR_VECT[i])     reg_d[i] = '0;
         else if (LOAD_VECT[i]) reg_d[i] = ac_q;
         else if (INC_VECT[i])  reg_d[i] = reg_q[i] + REG_W'(STRIDE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) reg_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NREG); i++) reg_q[i] <= reg_d[i];
      end
   end

   // While a read is pending only the returning data may touch AC.
   always_comb begin
      ac_d = ac_q;
      c_d  = c_q;
      if (state_q == S_WAIT) begin
         if (MI_valid) ac_d = REG_W'(MI_data);
      end else if (CLR_AC) begin
         ac_d = '0;
      end else if (LD_ALU_AC) begin
         ac_d = alu_res;
         c_d  = alu_carry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ac_q <= '0;
         c_q  <= 1'b0;
         z_q  <= 1'b1;
         z1_q <= 1'b0;
      end else begin
         ac_q <= ac_d;
         c_q  <= c_d;
         z_q  <= (ac_d == '0);
         z1_q <= (ac_d == REG_W'(1));
      end
   end

   // Read handshake; the address is captured at request time and held.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mi_rd_q  <= 1'b0;
         busy_q   <= 1'b0;
         mi_add_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (MI_req) begin
                  state_q  <= S_WAIT;
                  mi_rd_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  mi_add_q <= reg_q[IW'(MI_IDX)];
               end
            end
            S_WAIT: begin
               if (MI_valid) begin
                  state_q <= S_IDLE;
                  mi_rd_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               mi_rd_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign MI_rd   = mi_rd_q;
   assign busy    = busy_q;
   assign MI_add  = mi_add_q;
   assign MO_add  = reg_q[IW'(MO_IDX)];
   assign MO_data = reg_q[IW'(MOD_IDX)][DATA_W-1:0];
   assign z       = z_q;
   assign z1      = z1_q;
   assign c       = c_q;

endmodule
